// File: rtl/crc_stream_check.sv
// crc_stream_check: serial CRC checker over a valid/ready stream with held result and saturating error count
module crc_stream_check #(
  parameter int N = 16,
  parameter int R = 7,
  parameter logic [R-1:0] DIV = 7'b1111011,
  parameter int W = 1,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_error,
  output logic [R-2:0]  out_syn,
  output logic [CW-1:0] err_count
);
  localparam int L = N + R - 1;
  localparam int BEATS = L / W;
  localparam int BW = $clog2(BEATS + 1);
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0] state;
  logic [BW-1:0] cnt;
  logic [R-2:0] rem, rem_n;
  logic [R-1:0] t;
  logic [L-W-1:0] sh;
  logic [L-1:0] sh_n;
  logic last;
  if ((L % W) != 0 || DIV[R-1] != 1'b1) begin : g_chk
    $error("crc_stream_check: L must be divisible by W and DIV[R-1] must be 1");
  end
  assign in_ready = state == COLLECT;
  assign out_valid = state == HOLD;
  assign sh_n = {sh, in_data};
  assign last = cnt == BW'(BEATS - 1);
  always_comb begin
    rem_n = rem;
    t = '0;
    for (int i = W - 1; i >= 0; i--) begin
      t = {rem_n, in_data[i]};
      t = t[R-1] ? t ^ DIV : t;
      rem_n = t[R-2:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
      cnt <= '0;
      rem <= '0;
      sh <= '0;
      out_data <= '0;
      out_error <= 1'b0;
      out_syn <= '0;
      err_count <= '0;
    end else if (clr) begin
      state <= COLLECT;
      cnt <= '0;
      rem <= '0;
      err_count <= '0;
    end else if (state == COLLECT) begin
      if (in_valid) begin
        sh <= sh_n[L-W-1:0];
        rem <= last ? '0 : rem_n;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          out_data <= sh_n[L-1:R-1];
          out_syn <= rem_n;
          out_error <= |rem_n;
          state <= HOLD;
        end
      end
    end else if (out_ready) begin
      state <= COLLECT;
      if (out_error && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_crc_stream_check.sv
// tb_crc_stream_check: directed table-driven checks of crc_stream_check for W=1 (CW=4) and W=2
module tb_crc_stream_check;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr1 = 1'b0, clr2 = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [0:0] d1 = '0;
  logic [1:0] d2 = '0;
  logic or1 = 1'b0, or2 = 1'b0;
  logic rdy1, rdy2, ov1, ov2, oe1, oe2;
  logic [15:0] od1, od2;
  logic [5:0] os1, os2;
  logic [3:0] ec1;
  logic [15:0] ec2;
  logic [3:0] exp1 = '0;
  logic [15:0] exp2 = '0;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [21:0] cw;
    logic [15:0] data;
    logic err;
    logic [5:0] syn;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  crc_stream_check #(.W(1), .CW(4)) u1 (
    .clk(clk), .rst(rst), .clr(clr1), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_error(oe1), .out_syn(os1),
    .err_count(ec1)
  );
  crc_stream_check #(.W(2)) u2 (
    .clk(clk), .rst(rst), .clr(clr2), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_error(oe2), .out_syn(os2),
    .err_count(ec2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send1(input logic [21:0] cw);
    for (int i = 21; i >= 0; i--) begin
      @(negedge clk);
      if (i == 0) chk("w1_early_valid", ov1, 0);
      v1 = 1'b1;
      d1 = cw[i];
    end
    @(negedge clk);
    v1 = 1'b0;
    chk("w1_latency_valid", ov1, 1);
  endtask

  task automatic recv1(input logic [15:0] dat, input logic e, input logic [5:0] syn);
    chk("w1_valid", ov1, 1);
    chk("w1_data", od1, dat);
    chk("w1_error", oe1, e);
    chk("w1_syn", os1, syn);
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    if (e && exp1 != 4'hF) exp1++;
    chk("w1_valid_drop", ov1, 0);
    chk("w1_ready_back", rdy1, 1);
    chk("w1_err_count", ec1, exp1);
  endtask

  task automatic send2(input logic [21:0] cw);
    for (int k = 10; k >= 0; k--) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        v2 = 1'b0;
        chk("w2_gap_ready", rdy2, 1);
        @(negedge clk);
      end
      v2 = 1'b1;
      d2 = cw[2*k+1 -: 2];
    end
    @(negedge clk);
    v2 = 1'b0;
    chk("w2_latency_valid", ov2, 1);
  endtask

  task automatic recv2(input logic [15:0] dat, input logic e, input logic [5:0] syn);
    chk("w2_data", od2, dat);
    chk("w2_error", oe2, e);
    chk("w2_syn", os2, syn);
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    if (e) exp2++;
    chk("w2_valid_drop", ov2, 0);
    chk("w2_err_count", ec2, exp2);
  endtask

  task automatic partial1();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      v1 = 1'b1;
      d1 = 1'b1;
    end
    @(negedge clk);
    v1 = 1'b0;
  endtask

  initial begin
    vecs[0] = '{22'h00007B, 16'h0001, 1'b0, 6'h00};
    vecs[1] = '{22'h00007A, 16'h0001, 1'b1, 6'h01};
    vecs[2] = '{22'h000000, 16'h0000, 1'b0, 6'h00};
    vecs[3] = '{22'h000040, 16'h0001, 1'b1, 6'h3B};
    vecs[4] = '{22'h000080, 16'h0002, 1'b1, 6'h0D};
    vecs[5] = '{22'h00008D, 16'h0002, 1'b0, 6'h00};
    vecs[6] = '{22'h00008F, 16'h0002, 1'b1, 6'h02};
    vecs[7] = '{22'h000001, 16'h0000, 1'b1, 6'h01};
    vecs[8] = '{22'h200000, 16'h8000, 1'b1, 6'h3E};
    vecs[9] = '{22'h20003E, 16'h8000, 1'b0, 6'h00};
    #12;
    chk("rst_in_ready", rdy1, 1);
    chk("rst_out_valid", ov1, 0);
    chk("rst_out_data", od1, 0);
    chk("rst_out_error", oe1, 0);
    chk("rst_out_syn", os1, 0);
    chk("rst_err_count", ec1, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      send1(vecs[n].cw);
      recv1(vecs[n].data, vecs[n].err, vecs[n].syn);
    end
    send1(22'h00007B);
    v1 = 1'b1;
    d1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", ov1, 1);
      chk("bp_ready", rdy1, 0);
      chk("bp_data", od1, 16'h0001);
      chk("bp_syn", os1, 0);
      @(negedge clk);
    end
    recv1(16'h0001, 1'b0, 6'h00);
    v1 = 1'b0;
    send1(22'h000000);
    recv1(16'h0000, 1'b0, 6'h00);
    partial1();
    rst = 1'b1;
    #2;
    chk("arst_valid", ov1, 0);
    chk("arst_ready", rdy1, 1);
    chk("arst_count", ec1, 0);
    @(negedge clk);
    rst = 1'b0;
    exp1 = '0;
    exp2 = '0;
    send1(22'h000000);
    recv1(16'h0000, 1'b0, 6'h00);
    send1(22'h00007A);
    recv1(16'h0001, 1'b1, 6'h01);
    partial1();
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    exp1 = '0;
    chk("clr_valid", ov1, 0);
    chk("clr_ready", rdy1, 1);
    chk("clr_count", ec1, 0);
    send1(22'h000000);
    recv1(16'h0000, 1'b0, 6'h00);
    for (int n = 0; n < 17; n++) begin
      send1(22'h00007A);
      recv1(16'h0001, 1'b1, 6'h01);
    end
    chk("sat_count", ec1, 4'hF);
    send2(22'h00007B);
    recv2(16'h0001, 1'b0, 6'h00);
    send2(22'h00007A);
    recv2(16'h0001, 1'b1, 6'h01);
    send2(22'h200000);
    recv2(16'h8000, 1'b1, 6'h3E);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
